// File: rtl/riscv_pkg.sv
// Shared core definitions: ALU opcodes, data/address widths and the operand-stage entry.
package riscv_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   localparam logic [REG_AW-1:0] REG_X0 = '0;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101
   } alu_op_e;

   typedef struct packed {
      logic [2:0]        opc;
      logic [XLEN-1:0]   a;
      logic [XLEN-1:0]   b;
      logic [REG_AW-1:0] rd;
      logic              illegal;
   } stage_entry_t;

   function automatic logic is_illegal_opc(input logic [2:0] opc);
      return opc inside {3'b110, 3'b111};
   endfunction

endpackage

// File: rtl/alu_operand_stage_if.sv
// ID/forwarding inputs and ALU-facing outputs of the operand stage, bundled as one bus.
interface alu_operand_stage_if
   import riscv_pkg::*;
();
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [2:0]        in_opc;
   logic [REG_AW-1:0] in_rs1_addr;
   logic [REG_AW-1:0] in_rs2_addr;
   logic [REG_AW-1:0] in_rd_addr;
   logic [XLEN-1:0]   in_rs1_val;
   logic [XLEN-1:0]   in_rs2_val;
   logic [XLEN-1:0]   in_imm;
   logic              in_use_imm;
   logic              mem_fwd_en;
   logic              wb_fwd_en;
   logic [REG_AW-1:0] mem_fwd_rd;
   logic [REG_AW-1:0] wb_fwd_rd;
   logic [XLEN-1:0]   mem_fwd_data;
   logic [XLEN-1:0]   wb_fwd_data;
   logic              out_valid;
   logic              out_ready;
   logic [2:0]        alu_opc;
   logic [XLEN-1:0]   alu_a;
   logic [XLEN-1:0]   alu_b;
   logic [REG_AW-1:0] out_rd_addr;
   logic              illegal_op;

   // Pipeline environment (ID, MEM/WB, ALU) side.
   modport master (
      output flush, in_valid, in_opc, in_rs1_addr, in_rs2_addr, in_rd_addr,
             in_rs1_val, in_rs2_val, in_imm, in_use_imm,
             mem_fwd_en, wb_fwd_en, mem_fwd_rd, wb_fwd_rd, mem_fwd_data, wb_fwd_data,
             out_ready,
      input  in_ready, out_valid, alu_opc, alu_a, alu_b, out_rd_addr, illegal_op
   );

   // Operand stage side.
   modport slave (
      input  flush, in_valid, in_opc, in_rs1_addr, in_rs2_addr, in_rd_addr,
             in_rs1_val, in_rs2_val, in_imm, in_use_imm,
             mem_fwd_en, wb_fwd_en, mem_fwd_rd, wb_fwd_rd, mem_fwd_data, wb_fwd_data,
             out_ready,
      output in_ready, out_valid, alu_opc, alu_a, alu_b, out_rd_addr, illegal_op
   );
endinterface

// File: rtl/alu_operand_stage_fwd_mux.sv
// Priority select for one source operand: x0, then MEM, then WB, then register file.
module fwd_mux
   import riscv_pkg::*;
(
   input  logic [REG_AW-1:0] i_rs_addr,
   input  logic [XLEN-1:0]   i_rs_val,
   input  logic              i_mem_en,
   input  logic [REG_AW-1:0] i_mem_rd,
   input  logic [XLEN-1:0]   i_mem_data,
   input  logic              i_wb_en,
   input  logic [REG_AW-1:0] i_wb_rd,
   input  logic [XLEN-1:0]   i_wb_data,
   output logic [XLEN-1:0]   o_val
);

   // NOTE: default assignment first so every path through the block drives o_val -- no latch.
   always_comb begin
      o_val = i_rs_val;
      if (i_rs_addr == REG_X0) begin
         o_val = '0;
      end else if (i_mem_en && (i_mem_rd == i_rs_addr)) begin
         o_val = i_mem_data;
      end else if (i_wb_en && (i_wb_rd == i_rs_addr)) begin
         o_val = i_wb_data;
      end
   end

endmodule

// File: rtl/alu_operand_stage.sv
// Execute-stage front end: resolves forwarded operands on accept and holds them in a
// main + skid pair so the ALU handshake runs at full rate without a comb path from out_ready.
module alu_operand_stage
   import riscv_pkg::*;
(
   input  logic               clk,
   input  logic               rst_n,
   alu_operand_stage_if.slave io_stage
);

   logic [XLEN-1:0] w_rs1_res;
   logic [XLEN-1:0] w_rs2_res;
   stage_entry_t    w_in_entry;
   logic            w_accept;
   logic            w_advance;

   stage_entry_t    r_main;
   stage_entry_t    r_skid;
   logic            r_main_valid;
   logic            r_skid_valid;

   fwd_mux u_fwd_rs1 (
      .i_rs_addr  (io_stage.in_rs1_addr),
      .i_rs_val   (io_stage.in_rs1_val),
      .i_mem_en   (io_stage.mem_fwd_en),
      .i_mem_rd   (io_stage.mem_fwd_rd),
      .i_mem_data (io_stage.mem_fwd_data),
      .i_wb_en    (io_stage.wb_fwd_en),
      .i_wb_rd    (io_stage.wb_fwd_rd),
      .i_wb_data  (io_stage.wb_fwd_data),
      .o_val      (w_rs1_res)
   );

   fwd_mux u_fwd_rs2 (
      .i_rs_addr  (io_stage.in_rs2_addr),
      .i_rs_val   (io_stage.in_rs2_val),
      .i_mem_en   (io_stage.mem_fwd_en),
      .i_mem_rd   (io_stage.mem_fwd_rd),
      .i_mem_data (io_stage.mem_fwd_data),
      .i_wb_en    (io_stage.wb_fwd_en),
      .i_wb_rd    (io_stage.wb_fwd_rd),
      .i_wb_data  (io_stage.wb_fwd_data),
      .o_val      (w_rs2_res)
   );

   assign w_in_entry = '{
      opc:     io_stage.in_opc,
      a:       w_rs1_res,
      b:       io_stage.in_use_imm ? io_stage.in_imm : w_rs2_res,
      rd:      io_stage.in_rd_addr,
      illegal: is_illegal_opc(io_stage.in_opc)
   };

   // Skid occupancy alone gates acceptance, so in_ready is a pure register output.
   assign io_stage.in_ready = ~r_skid_valid;
   assign w_accept          = io_stage.in_valid & ~r_skid_valid;
   assign w_advance         = io_stage.out_ready | ~r_main_valid;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_main       <= '0;
      end else if (io_stage.flush) begin
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_advance) begin
         if (r_skid_valid) begin
            r_main       <= r_skid;
            r_main_valid <= 1'b1;
            r_skid_valid <= 1'b0;
         end else if (w_accept) begin
            r_main       <= w_in_entry;
            r_main_valid <= 1'b1;
         end else begin
            r_main_valid <= 1'b0;
         end
      end else if (w_accept) begin
         r_skid_valid <= 1'b1;
      end
   end

   // NOTE: skid payload has no reset; it is only ever read while r_skid_valid is set.
   always_ff @(posedge clk) begin
      if (!io_stage.flush && !w_advance && w_accept) begin
         r_skid <= w_in_entry;
      end
   end

   assign io_stage.out_valid   = r_main_valid;
   assign io_stage.alu_opc     = r_main.opc;
   assign io_stage.alu_a       = r_main.a;
   assign io_stage.alu_b       = r_main.b;
   assign io_stage.out_rd_addr = r_main.rd;
   assign io_stage.illegal_op  = r_main.illegal;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench: directed vectors push hand-computed entries; a monitor pops on each ALU handshake.
module tb_alu_operand_stage;

   typedef struct {
      logic [2:0]  opc;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;

   logic clk;
   logic rst_n;
   int   n_checks;
   int   n_errors;
   exp_t sb[$];

   alu_operand_stage_if sif ();

   alu_operand_stage dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .io_stage (sif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Monitor: pops one expected entry per handshake and checks stability while stalled.
   initial begin : monitor
      logic        prev_stall;
      logic [31:0] prev_a, prev_b;
      logic [2:0]  prev_opc;
      exp_t        e;
      prev_stall = 1'b0;
      prev_a = '0; prev_b = '0; prev_opc = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 1'b0;
         end else begin
            if (sif.out_valid && sif.out_ready) begin
               if (sb.size() == 0) begin
                  check("unexpected_out", 32'(sif.out_valid), 32'd0);
               end else begin
                  e = sb.pop_front();
                  check("out_opc", 32'(sif.alu_opc), 32'(e.opc));
                  check("out_a", sif.alu_a, e.a);
                  check("out_b", sif.alu_b, e.b);
                  check("out_rd", 32'(sif.out_rd_addr), 32'(e.rd));
                  check("out_illegal", 32'(sif.illegal_op), 32'(e.ill));
               end
            end
            if (sif.out_valid && !sif.out_ready) begin
               if (prev_stall) begin
                  check("stall_stable_a", sif.alu_a, prev_a);
                  check("stall_stable_b", sif.alu_b, prev_b);
                  check("stall_stable_opc", 32'(sif.alu_opc), 32'(prev_opc));
               end
               prev_stall = 1'b1;
               prev_a = sif.alu_a; prev_b = sif.alu_b; prev_opc = sif.alu_opc;
            end else begin
               prev_stall = 1'b0;
            end
         end
      end
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1);
   end

   task automatic set_fwd(input logic m_en, input logic [4:0] m_rd, input logic [31:0] m_d,
                          input logic w_en, input logic [4:0] w_rd, input logic [31:0] w_d);
      sif.mem_fwd_en = m_en; sif.mem_fwd_rd = m_rd; sif.mem_fwd_data = m_d;
      sif.wb_fwd_en  = w_en; sif.wb_fwd_rd  = w_rd; sif.wb_fwd_data  = w_d;
   endtask

   task automatic drive(input logic [2:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                        input logic [31:0] imm, input logic use_imm);
      sif.in_opc = opc; sif.in_rs1_addr = rs1; sif.in_rs2_addr = rs2; sif.in_rd_addr = rd;
      sif.in_rs1_val = v1; sif.in_rs2_val = v2; sif.in_imm = imm; sif.in_use_imm = use_imm;
      sif.in_valid = 1'b1;
   endtask

   // Issues one instruction (called at posedge+1) and records the hand-computed entry.
   task automatic send(input logic [2:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic [31:0] v1, input logic [31:0] v2,
                       input logic [31:0] imm, input logic use_imm, input logic ill,
                       input logic [31:0] exp_a, input logic [31:0] exp_b);
      int budget;
      budget = 0;
      while (!sif.in_ready && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      check("send_in_ready", 32'(sif.in_ready), 32'd1);
      drive(opc, rs1, rs2, rd, v1, v2, imm, use_imm);
      sb.push_back('{opc: opc, a: exp_a, b: exp_b, rd: rd, ill: ill});
      @(posedge clk); #1;
      sif.in_valid = 1'b0;
   endtask

   task automatic drain();
      int budget;
      budget = 0;
      sif.out_ready = 1'b1;
      while ((sb.size() != 0 || sif.out_valid) && budget < 20) begin
         @(posedge clk); #1;
         budget++;
      end
      check("drain_empty", 32'(sb.size()), 32'd0);
   endtask

   initial begin : stimulus
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      sif.flush = 1'b0;
      sif.in_valid = 1'b0;
      sif.out_ready = 1'b1;
      drive(3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 1'b0);
      sif.in_valid = 1'b0;
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

      #2;
      check("rst_out_valid", 32'(sif.out_valid), 32'd0);
      check("rst_in_ready", 32'(sif.in_ready), 32'd1);
      check("rst_alu_opc", 32'(sif.alu_opc), 32'd0);
      check("rst_alu_a", sif.alu_a, 32'd0);
      check("rst_alu_b", sif.alu_b, 32'd0);
      check("rst_rd", 32'(sif.out_rd_addr), 32'd0);
      check("rst_illegal", 32'(sif.illegal_op), 32'd0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      check("post_rst_in_ready", 32'(sif.in_ready), 32'd1);

      // Basic ADD, one-cycle latency.
      send(3'b000, 5'd3, 5'd4, 5'd1, 32'd5, 32'd7, 32'h0, 1'b0, 1'b0, 32'd5, 32'd7);
      check("lat_out_valid", 32'(sif.out_valid), 32'd1);
      check("lat_alu_a", sif.alu_a, 32'd5);

      // Forwarding priority: MEM beats WB, WB beats register file, x0 always zero.
      set_fwd(1'b1, 5'd6, 32'h11, 1'b1, 5'd6, 32'h22);
      send(3'b001, 5'd6, 5'd2, 5'd7, 32'h33, 32'h8, 32'h0, 1'b0, 1'b0, 32'h11, 32'h8);
      set_fwd(1'b0, 5'd6, 32'h11, 1'b1, 5'd6, 32'h22);
      send(3'b010, 5'd6, 5'd2, 5'd8, 32'h33, 32'h8, 32'h0, 1'b0, 1'b0, 32'h22, 32'h8);
      set_fwd(1'b1, 5'd0, 32'h44, 1'b1, 5'd0, 32'h55);
      send(3'b011, 5'd0, 5'd0, 5'd9, 32'h66, 32'h77, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
      set_fwd(1'b1, 5'd5, 32'hAA, 1'b1, 5'd7, 32'hBB);
      send(3'b100, 5'd7, 5'd5, 5'd10, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 32'hBB, 32'hAA);
      // Address compare must use all five bits (5'd22 vs 5'd6 differ only in bit 4).
      set_fwd(1'b1, 5'd22, 32'hCC, 1'b0, 5'd0, 32'h0);
      send(3'b101, 5'd6, 5'd1, 5'd11, 32'h123, 32'h4, 32'h0, 1'b0, 1'b0, 32'h123, 32'h4);

      // Immediate overrides forwarded rs2.
      set_fwd(1'b1, 5'd8, 32'h99, 1'b0, 5'd0, 32'h0);
      send(3'b000, 5'd1, 5'd8, 5'd12, 32'h10, 32'h20, 32'hFFFF_FFFC, 1'b1, 1'b0, 32'h10, 32'hFFFF_FFFC);
      set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
      drain();

      // Backpressure: A to main, B to skid, C held upstream.
      sif.out_ready = 1'b0;
      send(3'b000, 5'd1, 5'd2, 5'd13, 32'h100, 32'h200, 32'h0, 1'b0, 1'b0, 32'h100, 32'h200);
      send(3'b001, 5'd3, 5'd2, 5'd14, 32'h300, 32'h0, 32'h7, 1'b1, 1'b0, 32'h300, 32'h7);
      drive(3'b100, 5'd4, 5'd5, 5'd15, 32'hF0, 32'h0F, 32'h0, 1'b0);
      sb.push_back('{opc: 3'b100, a: 32'hF0, b: 32'h0F, rd: 5'd15, ill: 1'b0});
      for (int i = 0; i < 3; i++) begin
         check("stall_in_ready", 32'(sif.in_ready), 32'd0);
         check("stall_out_valid", 32'(sif.out_valid), 32'd1);
         check("stall_alu_a", sif.alu_a, 32'h100);
         @(posedge clk); #1;
      end
      sif.out_ready = 1'b1;
      @(posedge clk); #1;
      check("stream_b_valid", 32'(sif.out_valid), 32'd1);
      check("stream_b_a", sif.alu_a, 32'h300);
      @(posedge clk); #1;
      sif.in_valid = 1'b0;
      check("stream_c_valid", 32'(sif.out_valid), 32'd1);
      check("stream_c_a", sif.alu_a, 32'hF0);
      drain();

      // Flush with both entries full and a same-cycle input.
      sif.out_ready = 1'b0;
      send(3'b010, 5'd1, 5'd2, 5'd16, 32'h5, 32'h6, 32'h0, 1'b0, 1'b0, 32'h5, 32'h6);
      send(3'b011, 5'd1, 5'd2, 5'd17, 32'h7, 32'h8, 32'h0, 1'b0, 1'b0, 32'h7, 32'h8);
      check("pre_flush_in_ready", 32'(sif.in_ready), 32'd0);
      @(posedge clk); #1;
      sif.flush = 1'b1;
      drive(3'b000, 5'd1, 5'd2, 5'd18, 32'h9, 32'hA, 32'h0, 1'b0);
      @(posedge clk); #1;
      sif.flush = 1'b0;
      sif.in_valid = 1'b0;
      sb.delete();
      check("flush_out_valid", 32'(sif.out_valid), 32'd0);
      check("flush_in_ready", 32'(sif.in_ready), 32'd1);
      sif.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("flush_no_emit", 32'(sif.out_valid), 32'd0);
      end

      // Illegal opcode held under stall, then asynchronous reset mid-cycle.
      sif.out_ready = 1'b0;
      send(3'b111, 5'd1, 5'd2, 5'd19, 32'h10, 32'h20, 32'h0, 1'b0, 1'b1, 32'h10, 32'h20);
      check("illegal_flag", 32'(sif.illegal_op), 32'd1);
      check("illegal_opc", 32'(sif.alu_opc), 32'd7);
      check("illegal_valid", 32'(sif.out_valid), 32'd1);
      send(3'b000, 5'd1, 5'd2, 5'd20, 32'h1, 32'h2, 32'h0, 1'b0, 1'b0, 32'h1, 32'h2);
      check("full_in_ready", 32'(sif.in_ready), 32'd0);
      #3 rst_n = 1'b0;
      #1;
      sb.delete();
      check("async_rst_valid", 32'(sif.out_valid), 32'd0);
      check("async_rst_opc", 32'(sif.alu_opc), 32'd0);
      check("async_rst_illegal", 32'(sif.illegal_op), 32'd0);
      check("async_rst_in_ready", 32'(sif.in_ready), 32'd1);
      #10 rst_n = 1'b1;
      sif.out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("post_rst_no_emit", 32'(sif.out_valid), 32'd0);
      end

      // Post-reset sanity: stage still works.
      send(3'b101, 5'd2, 5'd3, 5'd21, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h1);
      drain();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
